// File: rtl/pulse_burst_pkg.sv
// Shared types and defaults for the pulse-burst generator.
package pulse_burst_pkg;

   localparam int DEFAULT_WIDTH     = 32;
   localparam int DEFAULT_DUR_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

endpackage

// File: rtl/phase_timer.sv
// Phase-length down-counter: loads max(dur, 1) and flags the final cycle of the phase.
module phase_timer
   import pulse_burst_pkg::*;
#(
   parameter int DUR_WIDTH = DEFAULT_DUR_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [DUR_WIDTH-1:0] dur,
   output logic                 expire
);

   logic [DUR_WIDTH-1:0] remain_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         remain_reg <= '0;
      end else if (load) begin
         // a zero duration still occupies one cycle
         remain_reg <= (dur == '0) ? DUR_WIDTH'(1) : dur;
      end else if (remain_reg != '0) begin
         remain_reg <= remain_reg - DUR_WIDTH'(1);
      end
   end

   assign expire = (remain_reg == DUR_WIDTH'(1));

endmodule

// File: rtl/pulse_burst_gen.sv
// Programmable pulse-burst generator: N pulses of H high / L low cycles, then a done strobe.
module pulse_burst_gen
   import pulse_burst_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int DUR_WIDTH = DEFAULT_DUR_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic [WIDTH-1:0]     count,
   input  logic [DUR_WIDTH-1:0] high_cycles,
   input  logic [DUR_WIDTH-1:0] low_cycles,
   output logic                 ready,
   output logic                 pulse,
   output logic [WIDTH-1:0]     emitted,
   output logic                 done
);

   state_t               state_reg;
   logic [WIDTH-1:0]     remain_reg;
   logic [DUR_WIDTH-1:0] high_reg;
   logic [DUR_WIDTH-1:0] low_reg;

   logic                 timer_load;
   logic [DUR_WIDTH-1:0] timer_dur;
   logic                 expire;
   logic                 last_pulse;

   assign last_pulse = (remain_reg == WIDTH'(1));

   // The timer is reloaded on every phase entry; on accept it takes the live input
   // because the latched copy is only written at that same edge.
   always_comb begin
      timer_load = 1'b0;
      timer_dur  = high_cycles;
      case (state_reg)
         IDLE: begin
            timer_load = start && (count != '0);
         end
         HIGH: begin
            timer_dur  = low_reg;
            timer_load = !stop && expire && !last_pulse;
         end
         LOW: begin
            timer_dur  = high_reg;
            timer_load = !stop && expire;
         end
         default: ;
      endcase
   end

   phase_timer #(
      .DUR_WIDTH(DUR_WIDTH)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (timer_load),
      .dur   (timer_dur),
      .expire(expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         remain_reg <= '0;
         high_reg   <= '0;
         low_reg    <= '0;
         ready      <= 1'b1;
         pulse      <= 1'b0;
         emitted    <= '0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  high_reg   <= high_cycles;
                  low_reg    <= low_cycles;
                  remain_reg <= count;
                  emitted    <= '0;
                  if (count == '0) begin
                     done <= 1'b1;
                  end else begin
                     state_reg <= HIGH;
                     ready     <= 1'b0;
                     pulse     <= 1'b1;
                  end
               end
            end
            HIGH: begin
               // abort wins even on the last high cycle, so that pulse is not counted
               if (stop) begin
                  state_reg <= IDLE;
                  ready     <= 1'b1;
                  pulse     <= 1'b0;
                  done      <= 1'b1;
               end else if (expire) begin
                  emitted    <= emitted + WIDTH'(1);
                  remain_reg <= remain_reg - WIDTH'(1);
                  pulse      <= 1'b0;
                  if (last_pulse) begin
                     state_reg <= IDLE;
                     ready     <= 1'b1;
                     done      <= 1'b1;
                  end else begin
                     state_reg <= LOW;
                  end
               end
            end
            LOW: begin
               if (stop) begin
                  state_reg <= IDLE;
                  ready     <= 1'b1;
                  pulse     <= 1'b0;
                  done      <= 1'b1;
               end else if (expire) begin
                  state_reg <= HIGH;
                  pulse     <= 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               ready     <= 1'b1;
               pulse     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Randomized bench for pulse_burst_gen against a closed-form burst timing model.
module tb_pulse_burst_gen;

   logic        clk = 1'b0;
   logic        clk_en = 1'b0;
   logic        rst;
   logic        start;
   logic        stop;
   logic [31:0] count;
   logic [7:0]  high_cycles;
   logic [7:0]  low_cycles;
   logic        ready;
   logic        pulse;
   logic [31:0] emitted;
   logic        done;

   pulse_burst_gen dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .count      (count),
      .high_cycles(high_cycles),
      .low_cycles (low_cycles),
      .ready      (ready),
      .pulse      (pulse),
      .emitted    (emitted),
      .done       (done)
   );

   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // model of the burst in progress: accept cycle plus effective N, H, L
   bit          busy = 0;
   int          bk, bn, bh, bl;
   bit          e_ready = 1, e_pulse = 0, e_done = 0;
   int unsigned e_emit = 0;

   int acc_cyc  = -1;
   int done_cyc = -1;
   int rises    = 0;
   bit prev_pulse = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
      end
   endtask

   // One clock cycle: check this cycle's outputs, drive inputs for it, predict the next cycle.
   task automatic step(input bit st, input bit sp, input int n, input int h, input int l);
      int off, endo, per, i, r;
      bit acc, abort, zero;
      @(negedge clk);
      cyc++;
      chk("ready", 64'(ready), 64'(e_ready));
      chk("pulse", 64'(pulse), 64'(e_pulse));
      chk("done", 64'(done), 64'(e_done));
      chk("emitted", 64'(emitted), 64'(e_emit));
      if (pulse && !prev_pulse) rises++;
      prev_pulse = pulse;
      if (done) done_cyc = cyc;

      start       = st;
      stop        = sp;
      count       = 32'(n);
      high_cycles = h[7:0];
      low_cycles  = l[7:0];

      acc   = e_ready && st;
      abort = 0;
      zero  = 0;
      if (acc) begin
         acc_cyc = cyc;
         bk      = cyc;
         bn      = n;
         bh      = (h[7:0] == 0) ? 1 : int'(h[7:0]);
         bl      = (l[7:0] == 0) ? 1 : int'(l[7:0]);
         busy    = (n != 0);
         zero    = (n == 0);
         rises   = 0;
      end else if (busy && sp) begin
         abort = 1;
         busy  = 0;
      end

      if (zero) begin
         e_ready = 1; e_pulse = 0; e_done = 1; e_emit = 0;
      end else if (abort) begin
         e_ready = 1; e_pulse = 0; e_done = 1;
      end else if (busy) begin
         off  = cyc - bk;
         endo = bn * bh + (bn - 1) * bl;
         per  = bh + bl;
         if (off < endo) begin
            i       = off / per;
            r       = off % per;
            e_pulse = (r < bh);
            e_emit  = i + ((r >= bh) ? 1 : 0);
            e_ready = 0;
            e_done  = 0;
         end else begin
            e_ready = 1; e_pulse = 0; e_done = 1; e_emit = bn;
            busy    = 0;
         end
      end else begin
         e_ready = 1; e_pulse = 0; e_done = 0;
      end
   endtask

   task automatic idle_step();
      step(0, 0, $urandom, $urandom, $urandom);
   endtask

   task automatic settle();
      for (int t = 0; t < 400 && !(e_ready && !e_done && !busy); t++) idle_step();
      idle_step();
   endtask

   task automatic run_burst(input int n, input int h, input int l,
                            input int exp_delta, input int exp_emit, input int exp_rises);
      int a;
      step(1, 0, n, h, l);
      a = acc_cyc;
      done_cyc = -1;
      for (int t = 0; t < 300 && done_cyc < 0; t++) idle_step();
      chk("done_delay", 64'(done_cyc - a), 64'(exp_delta));
      chk("emit_final", 64'(emitted), 64'(exp_emit));
      chk("rise_count", 64'(rises), 64'(exp_rises));
   endtask

   initial begin
      int a1;
      rst = 1; start = 0; stop = 0; count = '0; high_cycles = '0; low_cycles = '0;
      #10;
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_pulse", 64'(pulse), 64'd0);
      chk("rst_emitted", 64'(emitted), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      clk_en = 1;
      @(negedge clk);
      rst = 0;

      idle_step();
      run_burst(5, 1, 1, 10, 5, 5);
      settle();
      run_burst(3, 4, 2, 17, 3, 3);
      settle();
      run_burst(0, 3, 3, 1, 0, 0);
      settle();
      run_burst(2, 0, 0, 4, 2, 2);
      settle();
      run_burst(1, 1, 1, 2, 1, 1);
      settle();

      // abort in the 2nd cycle of the 4th high phase
      step(1, 0, 10, 3, 3);
      a1 = acc_cyc;
      done_cyc = -1;
      repeat (19) idle_step();
      step(0, 1, 7, 7, 7);
      idle_step();
      chk("abort_done", 64'(done_cyc - a1), 64'd21);
      chk("abort_emit", 64'(emitted), 64'd3);
      settle();

      // start held high: second burst accepted in the done cycle
      step(1, 0, 2, 2, 1);
      a1 = acc_cyc;
      for (int t = 0; t < 50 && acc_cyc == a1; t++) step(1, 0, 2, 2, 1);
      chk("b2b_gap", 64'(acc_cyc - a1), 64'd6);
      step(0, 0, 2, 2, 1);
      chk("b2b_emit_clr", 64'(emitted), 64'd0);
      settle();

      // asynchronous reset in the middle of a burst
      step(1, 0, 4, 3, 2);
      repeat (6) idle_step();
      @(posedge clk);
      #2 rst = 1;
      #1;
      chk("arst_ready", 64'(ready), 64'd1);
      chk("arst_pulse", 64'(pulse), 64'd0);
      chk("arst_emitted", 64'(emitted), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      @(negedge clk);
      cyc++;
      rst = 0; start = 0; stop = 0;
      busy = 0; e_ready = 1; e_pulse = 0; e_done = 0; e_emit = 0; prev_pulse = 0;

      for (int t = 0; t < 1500; t++) begin
         step(($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      end
      settle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
